reloj_hora: RTL

//  Downstream consumer of the UART time-frame receiver. Loads the 6 ASCII digits (HHMMSS)

---
 rtl/reloj_pkg.sv | 31 +++
 rtl/reloj_hora_contador_bcd_mod.sv | 49 ++++
 rtl/reloj_hora.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/reloj_pkg.sv
// Shared constants, BCD time types and digit check for the reloj_hora clock.
// Combinational helpers only. No latency and no backpressure.
package reloj_pkg;

  localparam logic [7:0] ASCII_CERO  = 8'h30;
  localparam logic [7:0] ASCII_NUEVE = 8'h39;

  // Byte positions inside the 48-bit ASCII frame. HT is the least significant byte.
  localparam int HT = 0;
  localparam int HU = 1;
  localparam int MT = 2;
  localparam int MU = 3;
  localparam int ST = 4;
  localparam int SU = 5;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] u;
  } bcd2_t;

  typedef struct packed {
    bcd2_t hh;
    bcd2_t mm;
    bcd2_t ss;
  } hora_t;

  function automatic logic es_digito(input logic [7:0] b);
    return (b >= ASCII_CERO) && (b <= ASCII_NUEVE);
  endfunction

endpackage

// File: rtl/reloj_hora_contador_bcd_mod.sv
// Two-digit BCD counter that wraps after MOD_T:MOD_U. It supports load and increment.
// dout is registered, so an update shows 1 cycle later. carry_out is combinational. No backpressure.
module contador_bcd_mod
  import reloj_pkg::*;
#(
  parameter int MOD_T = 5,
  parameter int MOD_U = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       inc,
  output logic [7:0] dout,
  output logic       carry_out
);

  localparam logic [3:0] MAX_T = 4'(MOD_T);
  localparam logic [3:0] MAX_U = 4'(MOD_U);

  bcd2_t val_q, val_d;
  logic  at_max;

  always_comb begin
    at_max    = (val_q.t == MAX_T) && (val_q.u == MAX_U);
    val_d     = val_q;
    carry_out = inc & ~load & at_max;
    if (load) begin
      val_d = bcd2_t'(din);
    end else if (inc) begin
      if (at_max) begin
        val_d = '0;
      end else if (val_q.u == 4'd9) begin
        val_d.t = val_q.t + 4'd1;
        val_d.u = 4'd0;
      end else begin
        val_d.u = val_q.u + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign dout = val_q;

endmodule

// File: rtl/reloj_hora.sv
// Running HH:MM:SS clock. It loads from an ASCII frame and re-emits the time as ASCII. The optional alarm is enabled by ALARM_EN.
// hora_out shows a time update 1 cycle after it happens. There is no backpressure: load edges are always accepted.
module reloj_hora
  import reloj_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] hora_in,
  input  logic        load,
  input  logic        run,
  output logic [47:0] hora_out,
  output logic        seg_tick,
  output logic        dia_tick,
  output logic        valid,
  output logic        err
`ifdef ALARM_EN
  ,
  input  logic [47:0] alarma_in,
  input  logic        alarma_set,
  output logic        alarma
`endif
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_TERM = PW'(CLK_HZ - 1);

  function automatic logic frame_ok(input logic [47:0] f);
    logic d;
    d = 1'b1;
    for (int i = 0; i < 6; i++) d = d & es_digito(f[i*8 +: 8]);
    return d
      && ((f[HT*8 +: 4] < 4'd2) || ((f[HT*8 +: 4] == 4'd2) && (f[HU*8 +: 4] <= 4'd3)))
      && (f[MT*8 +: 4] <= 4'd5)
      && (f[ST*8 +: 4] <= 4'd5);
  endfunction

  function automatic hora_t to_bcd(input logic [47:0] f);
    hora_t h;
    h.hh.t = f[HT*8 +: 4];
    h.hh.u = f[HU*8 +: 4];
    h.mm.t = f[MT*8 +: 4];
    h.mm.u = f[MU*8 +: 4];
    h.ss.t = f[ST*8 +: 4];
    h.ss.u = f[SU*8 +: 4];
    return h;
  endfunction

  function automatic logic [47:0] to_ascii(input hora_t h);
    logic [47:0] r;
    r[HT*8 +: 8] = ASCII_CERO | {4'b0, h.hh.t};
    r[HU*8 +: 8] = ASCII_CERO | {4'b0, h.hh.u};
    r[MT*8 +: 8] = ASCII_CERO | {4'b0, h.mm.t};
    r[MU*8 +: 8] = ASCII_CERO | {4'b0, h.mm.u};
    r[ST*8 +: 8] = ASCII_CERO | {4'b0, h.ss.t};
    r[SU*8 +: 8] = ASCII_CERO | {4'b0, h.ss.u};
    return r;
  endfunction

  logic [PW-1:0] pre_q, pre_d;
  logic          load_q;
  logic          valid_q, valid_d, err_q, err_d;
  logic          seg_q, seg_d, dia_q, dia_d;
  logic [47:0]   out_q, out_d;
  logic          load_edge, load_ok, tick, tick_eff;
  logic          c_ss, c_mm, c_hh;
  hora_t         hora, hora_ld;

  always_comb begin
    load_edge = load & ~load_q;
    load_ok   = load_edge & frame_ok(hora_in);
    hora_ld   = to_bcd(hora_in);
    tick      = run & (pre_q == PRE_TERM);
    // A valid load on the terminal count restarts the second, so that tick is dropped.
    tick_eff  = tick & ~load_ok;
    pre_d     = pre_q;
    if (load_ok)  pre_d = '0;
    else if (tick) pre_d = '0;
    else if (run)  pre_d = pre_q + PW'(1);
    valid_d = valid_q | load_ok;
    err_d   = load_edge & ~load_ok;
    seg_d   = tick_eff;
    dia_d   = c_hh;
    out_d   = to_ascii(hora);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      seg_q   <= 1'b0;
      dia_q   <= 1'b0;
      out_q   <= {6{ASCII_CERO}};
    end else begin
      pre_q   <= pre_d;
      load_q  <= load;
      valid_q <= valid_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      dia_q   <= dia_d;
      out_q   <= out_d;
    end
  end

  contador_bcd_mod #(.MOD_T(5), .MOD_U(9)) u_ss (
    .clk(clk), .rst(rst), .load(load_ok), .din(hora_ld.ss),
    .inc(tick_eff), .dout(hora.ss), .carry_out(c_ss)
  );
  contador_bcd_mod #(.MOD_T(5), .MOD_U(9)) u_mm (
    .clk(clk), .rst(rst), .load(load_ok), .din(hora_ld.mm),
    .inc(c_ss), .dout(hora.mm), .carry_out(c_mm)
  );
  contador_bcd_mod #(.MOD_T(2), .MOD_U(3)) u_hh (
    .clk(clk), .rst(rst), .load(load_ok), .din(hora_ld.hh),
    .inc(c_mm), .dout(hora.hh), .carry_out(c_hh)
  );

  assign hora_out = out_q;
  assign seg_tick = seg_q;
  assign dia_tick = dia_q;
  assign valid    = valid_q;
  assign err      = err_q;

`ifdef ALARM_EN
  logic       aset_q, armed_q, armed_d, alarma_q, alarma_d;
  logic [5:0] acnt_q, acnt_d;
  hora_t      alm_q, alm_d;

  always_comb begin
    alm_d    = alm_q;
    armed_d  = armed_q;
    alarma_d = alarma_q;
    acnt_d   = acnt_q;
    if (alarma_set & ~aset_q & frame_ok(alarma_in)) begin
      alm_d   = to_bcd(alarma_in);
      armed_d = 1'b1;
    end
    // seg_q is high in the cycle where the counters already hold the new time.
    if (alarma_q) begin
      if (seg_q) begin
        if (acnt_q == 6'd59) alarma_d = 1'b0;
        else                 acnt_d   = acnt_q + 6'd1;
      end
    end else if (seg_q & armed_q & (hora == alm_q)) begin
      alarma_d = 1'b1;
      acnt_d   = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aset_q   <= 1'b0;
      armed_q  <= 1'b0;
      alarma_q <= 1'b0;
      acnt_q   <= '0;
      alm_q    <= '0;
    end else begin
      aset_q   <= alarma_set;
      armed_q  <= armed_d;
      alarma_q <= alarma_d;
      acnt_q   <= acnt_d;
      alm_q    <= alm_d;
    end
  end

  assign alarma = alarma_q;
`endif

endmodule
